fetch_unit: RTL and testbench

Instruction fetch stage that consumes the PC produced by the program counter and issues instruction-memory reads. It captures returned instruction words into a small in-order buffer for decode, with valid/ready handshakes on the memory and decode sides. It drives the PC's stall input and discards stale instructions when a taken branch flushes the front end.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 62 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the reset PC, the fetch FSM state type and the buffered entry type.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of fetched {pc, instr} entries with push/pop/clear.
// Ports: clock, reset (async low), clear_i, push_i/push_entry_i, pop_i,
// head_o, empty_o, full_o, count_o.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  logic do_pop;
  logic do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head reads as zero when empty so decode never sees stale data.
  assign head_o = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory read, in-order buffer.
// Ports: clock/reset, pc_in/pc_stall, flush, mem_req_*, mem_resp_*, inst_*.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pend_pc_q;

  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          buf_empty;
  logic          buf_full;
  logic [CW-1:0] buf_count;

  logic          pop_req;
  logic          push;
  logic          fire;
  logic          in_wait;
  logic [CW:0]   occ;

  assign in_wait = (state_q == WAIT);
  assign pop_req = inst_valid && inst_ready;

  // Occupancy counts the in-flight word as already buffered.
  assign occ = {1'b0, buf_count} + (CW+1)'(in_wait) - (CW+1)'(pop_req);

  assign mem_req_valid = reset && !flush
                      && (occ < (CW+1)'(DEPTH))
                      && ((state_q == IDLE) || (in_wait && mem_resp_valid));
  assign mem_req_addr  = pc_in;
  assign fire          = mem_req_valid && mem_req_ready;
  assign pc_stall      = !fire;

  assign push = in_wait && mem_resp_valid && !flush;

  assign push_entry.pc    = 32'(pend_pc_q);
  assign push_entry.instr = 32'(mem_resp_data);

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (flush),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop_req && !flush),
    .head_o       (head),
    .empty_o      (buf_empty),
    .full_o       (buf_full),
    .count_o      (buf_count)
  );

  assign inst_valid = !buf_empty;
  assign inst_data  = DATA_W'(head.instr);
  assign inst_pc    = ADDR_W'(head.pc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      if (fire) pend_pc_q <= pc_in;
      unique case (state_q)
        IDLE: begin
          if (fire) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) state_q <= fire ? WAIT : IDLE;
          else if (flush)     state_q <= DRAIN;
        end
        DRAIN: begin
          if (mem_resp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A response with nothing outstanding, or a push into a full buffer,
  // means the memory broke its one-response-per-request contract.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(state_q == IDLE && mem_resp_valid));
      assert (!(push && buf_full && !pop_req));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit.
// Memory and PC environment live here; expectations come from a queue model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_stall       (pc_stall),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  logic [31:0] pc;
  logic [31:0] redirect;
  int          lat;
  bit          busy;
  int          cnt;
  logic [31:0] m_addr;
  int          m_epoch;
  int          epoch;

  // Expected decode-side contents, oldest first: {pc, instr}
  logic [63:0] q[$];

  int          n_req;
  int          n_stall;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1 with inputs driven; ends at next posedge+1.
  task automatic tick();
    bit          resp_cur;
    bit          pop;
    bit          req_e;
    bit          acc;
    bit          stall_s;
    bit          was_resp;
    logic [31:0] acc_addr;
    int          occ;
    #4;
    resp_cur = mem_resp_valid && busy && (m_epoch == epoch);
    pop      = (q.size() != 0) && inst_ready;
    occ      = q.size() - int'(pop) + int'(resp_cur);
    req_e    = !flush && (!busy || resp_cur) && (occ < DEPTH);
    chk("inst_valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst_pc", inst_pc, q[0][63:32]);
      chk("inst_data", inst_data, q[0][31:0]);
    end
    chk("req_valid", mem_req_valid, req_e);
    chk("pc_stall", pc_stall, !(req_e && mem_req_ready));
    chk("req_addr", mem_req_addr, pc_in);
    acc      = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    stall_s  = pc_stall;
    if (acc) begin
      n_req++;
      last_addr = acc_addr;
    end
    if (stall_s) n_stall++;
    if (flush) begin
      q.delete();
      epoch++;
    end else begin
      if (pop) void'(q.pop_front());
      if (resp_cur) q.push_back({m_addr, mem_resp_data});
    end
    was_resp = mem_resp_valid;
    @(posedge clock);
    #1;
    if (was_resp) begin
      busy           = 1'b0;
      mem_resp_valid = 1'b0;
    end
    if (acc) begin
      busy    = 1'b1;
      cnt     = lat;
      m_addr  = acc_addr;
      m_epoch = epoch;
    end
    if (flush) begin
      pc    = redirect;
      flush = 1'b0;
    end else if (!stall_s) begin
      pc = pc + 32'd4;
    end
    pc_in = pc;
    if (busy && !mem_resp_valid) begin
      cnt--;
      if (cnt <= 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
      end
    end
  endtask

  task automatic drain();
    mem_req_ready = 1'b0;
    inst_ready    = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    reset          = 1'b0;
    pc             = RESET_PC;
    pc_in          = 32'h0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect       = 32'h0;
    lat            = 1;
    busy           = 1'b0;
    cnt            = 0;
    m_addr         = 32'h0;
    m_epoch        = 0;
    epoch          = 0;
    n_req          = 0;
    n_stall        = 0;
    last_addr      = 32'h0;

    // Reset values
    #2;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_pc_stall", pc_stall, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    pc_in = pc;

    // Zero-wait memory, continuous stream
    lat           = 1;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    n_stall       = 0;
    repeat (8) tick();
    chk("zw_stall_cycles", n_stall, 0);

    // Latency 3: one request every 3 cycles
    lat     = 3;
    n_req   = 0;
    n_stall = 0;
    repeat (12) tick();
    chk("l3_requests", n_req, 4);
    chk("l3_stall_cycles", n_stall, 8);

    // Decode stalled: buffer fills to DEPTH
    drain();
    lat           = 1;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    n_req         = 0;
    repeat (6) tick();
    chk("full_requests", n_req, DEPTH);
    n_req      = 0;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (4) tick();
    chk("one_pop_requests", n_req, 1);

    // Flush while WAIT, response two cycles later
    drain();
    lat           = 3;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b1;
    n_req         = 0;
    tick();
    redirect = 32'h0040_0040;
    flush    = 1'b1;
    tick();
    repeat (3) tick();
    chk("drain_requests", n_req, 2);
    chk("redirect_addr", last_addr, 32'h0040_0040);

    // Flush coinciding with response and pop
    drain();
    lat           = 2;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    n_req         = 0;
    repeat (4) tick();
    redirect   = 32'h0040_0100;
    flush      = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    chk("flush_resp_requests", n_req, 3);
    chk("flush_resp_addr", last_addr, 32'h0040_0100);

    // Reset mid-WAIT with a buffered entry
    drain();
    lat           = 3;
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    repeat (5) tick();
    chk("pre_rst_valid", inst_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", inst_valid, 1'b0);
    chk("async_rst_req", mem_req_valid, 1'b0);
    chk("async_rst_stall", pc_stall, 1'b1);
    q.delete();
    busy           = 1'b0;
    mem_resp_valid = 1'b0;
    epoch++;
    pc    = RESET_PC;
    pc_in = pc;
    @(posedge clock);
    #1;
    chk("held_rst_valid", inst_valid, 1'b0);
    chk("held_rst_req", mem_req_valid, 1'b0);
    reset      = 1'b1;
    inst_ready = 1'b1;
    n_req      = 0;
    tick();
    chk("post_rst_requests", n_req, 1);
    chk("post_rst_addr", last_addr, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready    = ($urandom_range(0, 2) != 0);
      lat           = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        flush    = 1'b1;
        redirect = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
